// File: rtl/sys_ctrl_gen.sv
// Command-frame controller: decodes RX opcode frames into register-file/ALU control and FIFO bytes.
// Optional inter-byte frame timeout is built when SYS_CTRL_TIMEOUT_EN is defined.
module sys_ctrl_gen #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUNC_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_DATA_IN,
    input  logic                    RX_DATA_VALID,
    output logic [ADDR_WIDTH-1:0]   RegFile_ADDRESS,
    output logic                    RegFile_WrEn,
    output logic                    RegFile_RdEn,
    output logic [DATA_WIDTH-1:0]   RegFile_WrData,
    input  logic [DATA_WIDTH-1:0]   RegFile_RdData,
    input  logic                    RegFile_DATA_VALID,
    output logic [FUNC_WIDTH-1:0]   ALU_FUNC,
    output logic                    ALU_EN,
    output logic                    ALU_CLK_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_DATA_VALID,
    output logic [DATA_WIDTH-1:0]   TX_DATA_OUT,
    output logic                    FIFO_WR,
    input  logic                    FIFO_FULL,
    output logic                    CMD_ERROR
);

    localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_OPS = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU   = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] OP_BURST = DATA_WIDTH'(8'hEE);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, GET_A, GET_B, GET_FN, GET_CNT,
        RF_WRITE, RF_READ, RF_WAIT, ALU_RUN, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    typedef enum logic [1:0] {MODE_WR, MODE_RD, MODE_BURST, MODE_ALU} mode_t;

    state_t                  state_q, state_d;
    mode_t                   mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    wren_q, wren_d;
    logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
    logic [FUNC_WIDTH-1:0]   func_q, func_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   res_hi_q, res_hi_d;
    logic                    err_q, err_d;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           tmr_q, tmr_d;
`endif

    function automatic logic is_get(input state_t s);
        return s inside {GET_ADDR, GET_DATA, GET_A, GET_B, GET_FN, GET_CNT};
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            mode_q   <= MODE_WR;
            addr_q   <= '0;
            cnt_q    <= '0;
            wren_q   <= 1'b0;
            wrdata_q <= '0;
            func_q   <= '0;
            tx_q     <= '0;
            res_hi_q <= '0;
            err_q    <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
            tmr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wren_q   <= wren_d;
            wrdata_q <= wrdata_d;
            func_q   <= func_d;
            tx_q     <= tx_d;
            res_hi_q <= res_hi_d;
            err_q    <= err_d;
`ifdef SYS_CTRL_TIMEOUT_EN
            tmr_q    <= tmr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wren_d   = 1'b0;
        wrdata_d = wrdata_q;
        func_d   = func_q;
        tx_d     = tx_q;
        res_hi_d = res_hi_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_DATA_VALID) begin
                    case (RX_DATA_IN)
                        OP_WRITE:   begin mode_d = MODE_WR;    state_d = GET_ADDR; end
                        OP_READ:    begin mode_d = MODE_RD;    state_d = GET_ADDR; end
                        OP_ALU_OPS: begin mode_d = MODE_ALU;   state_d = GET_A;    end
                        OP_ALU:     begin mode_d = MODE_ALU;   state_d = GET_FN;   end
                        OP_BURST:   begin mode_d = MODE_BURST; state_d = GET_ADDR; end
                        default:    err_d = 1'b1;
                    endcase
                end
            end
            GET_ADDR: begin
                if (RX_DATA_VALID) begin
                    addr_d = RX_DATA_IN[ADDR_WIDTH-1:0];
                    if (mode_q == MODE_WR) begin
                        state_d = GET_DATA;
                    end else if (mode_q == MODE_BURST) begin
                        state_d = GET_CNT;
                    end else begin
                        cnt_d   = DATA_WIDTH'(1);
                        state_d = RF_READ;
                    end
                end
            end
            GET_DATA: begin
                if (RX_DATA_VALID) begin
                    wrdata_d = RX_DATA_IN;
                    wren_d   = 1'b1;
                    state_d  = RF_WRITE;
                end
            end
            // Operand writes are registered strobes so the next operand byte can follow immediately.
            GET_A: begin
                if (RX_DATA_VALID) begin
                    addr_d   = '0;
                    wrdata_d = RX_DATA_IN;
                    wren_d   = 1'b1;
                    state_d  = GET_B;
                end
            end
            GET_B: begin
                if (RX_DATA_VALID) begin
                    addr_d   = ADDR_WIDTH'(1);
                    wrdata_d = RX_DATA_IN;
                    wren_d   = 1'b1;
                    state_d  = GET_FN;
                end
            end
            GET_FN: begin
                if (RX_DATA_VALID) begin
                    func_d  = RX_DATA_IN[FUNC_WIDTH-1:0];
                    state_d = ALU_RUN;
                end
            end
            GET_CNT: begin
                if (RX_DATA_VALID) begin
                    if (RX_DATA_IN == '0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = RX_DATA_IN;
                        state_d = RF_READ;
                    end
                end
            end
            RF_WRITE: state_d = IDLE;
            RF_READ:  state_d = RF_WAIT;
            RF_WAIT: begin
                if (RegFile_DATA_VALID) begin
                    tx_d    = RegFile_RdData;
                    state_d = TX_LO;
                end
            end
            ALU_RUN, ALU_WAIT: begin
                state_d = ALU_WAIT;
                if (ALU_DATA_VALID) begin
                    tx_d     = ALU_OUT[DATA_WIDTH-1:0];
                    res_hi_d = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d  = TX_LO;
                end
            end
            // TX_LO is shared by ALU low bytes and every register-read byte of a burst.
            TX_LO: begin
                if (!FIFO_FULL) begin
                    if (mode_q == MODE_ALU) begin
                        tx_d    = res_hi_q;
                        state_d = TX_HI;
                    end else begin
                        cnt_d = cnt_q - DATA_WIDTH'(1);
                        if (cnt_q == DATA_WIDTH'(1)) begin
                            state_d = IDLE;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = RF_READ;
                        end
                    end
                end
            end
            TX_HI: begin
                if (!FIFO_FULL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef SYS_CTRL_TIMEOUT_EN
        // Counter holds the number of cycles since the last strobe while a frame is open.
        tmr_d = '0;
        if (is_get(state_d)) tmr_d = RX_DATA_VALID ? TW'(1) : tmr_q + TW'(1);
        if (is_get(state_q) && !RX_DATA_VALID && (tmr_q + TW'(1) == TW'(TIMEOUT_CYCLES))) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmr_d   = '0;
        end
`endif
    end

    assign RegFile_ADDRESS = addr_q;
    assign RegFile_WrEn    = wren_q;
    assign RegFile_WrData  = wrdata_q;
    assign RegFile_RdEn    = (state_q == RF_READ);
    assign ALU_FUNC        = func_q;
    assign ALU_EN          = (state_q == ALU_RUN);
    assign ALU_CLK_EN      = (state_q == ALU_RUN) || (state_q == ALU_WAIT);
    assign TX_DATA_OUT     = tx_q;
    assign FIFO_WR         = ((state_q == TX_LO) || (state_q == TX_HI)) && !FIFO_FULL;
    assign CMD_ERROR       = err_q;

endmodule

// File: tb/tb_sys_ctrl_gen.sv
// Directed testbench for sys_ctrl_gen with a small register-file and ALU model around the DUT.
module tb_sys_ctrl_gen;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_DATA_IN = '0;
    logic        RX_DATA_VALID = 1'b0;
    logic [3:0]  RegFile_ADDRESS;
    logic        RegFile_WrEn, RegFile_RdEn;
    logic [7:0]  RegFile_WrData;
    logic [7:0]  RegFile_RdData;
    logic        RegFile_DATA_VALID;
    logic [3:0]  ALU_FUNC;
    logic        ALU_EN, ALU_CLK_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_DATA_VALID;
    logic [7:0]  TX_DATA_OUT;
    logic        FIFO_WR;
    logic        FIFO_FULL = 1'b0;
    logic        CMD_ERROR;

    sys_ctrl_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUNC_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .RX_DATA_IN(RX_DATA_IN), .RX_DATA_VALID(RX_DATA_VALID),
        .RegFile_ADDRESS(RegFile_ADDRESS), .RegFile_WrEn(RegFile_WrEn), .RegFile_RdEn(RegFile_RdEn),
        .RegFile_WrData(RegFile_WrData), .RegFile_RdData(RegFile_RdData),
        .RegFile_DATA_VALID(RegFile_DATA_VALID),
        .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN), .ALU_CLK_EN(ALU_CLK_EN),
        .ALU_OUT(ALU_OUT), .ALU_DATA_VALID(ALU_DATA_VALID),
        .TX_DATA_OUT(TX_DATA_OUT), .FIFO_WR(FIFO_WR), .FIFO_FULL(FIFO_FULL),
        .CMD_ERROR(CMD_ERROR)
    );

    always #5 CLK = ~CLK;

    int chk = 0;
    int pass = 0;
    int cyc = 0;
    int strobe_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Register file and ALU environment models
    logic [7:0] regs [16];
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            RegFile_DATA_VALID <= 1'b0;
            RegFile_RdData     <= '0;
            ALU_DATA_VALID     <= 1'b0;
            ALU_OUT            <= '0;
        end else begin
            if (RegFile_WrEn) regs[RegFile_ADDRESS] <= RegFile_WrData;
            RegFile_DATA_VALID <= RegFile_RdEn;
            if (RegFile_RdEn) RegFile_RdData <= regs[RegFile_ADDRESS];
            ALU_DATA_VALID <= 1'b0;
            if (ALU_EN && ALU_CLK_EN) begin
                ALU_DATA_VALID <= 1'b1;
                case (ALU_FUNC)
                    4'd0:    ALU_OUT <= {8'h00, regs[0]} + {8'h00, regs[1]};
                    4'd2:    ALU_OUT <= {8'h00, regs[0]} * {8'h00, regs[1]};
                    default: ALU_OUT <= 16'h0000;
                endcase
            end
        end
    end

    // Event monitor, sampled mid-cycle
    logic [3:0] wr_a [$];
    logic [7:0] wr_d [$];
    logic [7:0] fifo_q [$];
    int rd_cnt = 0, err_cnt = 0, alu_en_cnt = 0, alu_clk_cnt = 0, viol = 0;
    int last_wr_cyc = 0, last_fifo_cyc = 0, last_err_cyc = 0;
    logic [3:0] alu_func_seen = '0;

    always @(negedge CLK) begin
        if (RegFile_WrEn) begin
            wr_a.push_back(RegFile_ADDRESS);
            wr_d.push_back(RegFile_WrData);
            last_wr_cyc = cyc;
        end
        if (RegFile_RdEn) rd_cnt++;
        if (FIFO_WR) begin
            fifo_q.push_back(TX_DATA_OUT);
            last_fifo_cyc = cyc;
        end
        if (FIFO_WR && FIFO_FULL) viol++;
        if (CMD_ERROR) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (ALU_EN) begin
            alu_en_cnt++;
            alu_func_seen = ALU_FUNC;
        end
        if (ALU_CLK_EN) alu_clk_cnt++;
    end

    // Called at posedge+1; returns at posedge+1 of the following cycle
    task automatic send_byte(input logic [7:0] b);
        RX_DATA_IN    = b;
        RX_DATA_VALID = 1'b1;
        strobe_cyc    = cyc;
        @(posedge CLK); #1;
        RX_DATA_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk++;
        if ({RegFile_ADDRESS, RegFile_WrEn, RegFile_RdEn, RegFile_WrData, ALU_FUNC, ALU_EN, ALU_CLK_EN} !== '0)
            $display("FAIL reset_rf_alu: got %h want 0", {RegFile_ADDRESS, RegFile_WrEn, RegFile_RdEn, RegFile_WrData, ALU_FUNC, ALU_EN, ALU_CLK_EN});
        else pass++;
        chk++;
        if ({TX_DATA_OUT, FIFO_WR, CMD_ERROR} !== '0)
            $display("FAIL reset_tx_err: got %h want 0", {TX_DATA_OUT, FIFO_WR, CMD_ERROR});
        else pass++;
        RST = 1'b1;
        idle(2);
    endtask

    task automatic test_write_read();
        int wb, fb, rsc;
        wb = wr_a.size(); fb = fifo_q.size();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        rsc = strobe_cyc;
        idle(4);
        chk++;
        if (wr_a.size() != wb + 1) $display("FAIL wr_count: got %0d want 1", wr_a.size() - wb);
        else pass++;
        chk++;
        if ({wr_a[wb], wr_d[wb]} !== {4'h5, 8'h3C}) $display("FAIL wr_addr_data: got %h/%h want 5/3c", wr_a[wb], wr_d[wb]);
        else pass++;
        chk++;
        if (last_wr_cyc - rsc != 1) $display("FAIL wr_timing: got %0d want 1", last_wr_cyc - rsc);
        else pass++;
        send_byte(8'hBB); send_byte(8'h05);
        rsc = strobe_cyc;
        idle(6);
        chk++;
        if (fifo_q.size() != fb + 1 || fifo_q[fb] !== 8'h3C)
            $display("FAIL rd_data: got %0d bytes first %h want 1 byte 3c", fifo_q.size() - fb, fifo_q[fb]);
        else pass++;
        chk++;
        if (last_fifo_cyc - rsc != 3) $display("FAIL rd_latency: got %0d want 3", last_fifo_cyc - rsc);
        else pass++;
    endtask

    task automatic test_alu_ops();
        int wb, fb, eb, cb;
        wb = wr_a.size(); fb = fifo_q.size(); eb = alu_en_cnt; cb = alu_clk_cnt;
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h00);
        idle(10);
        chk++;
        if (wr_a.size() != wb + 2 || {wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]} !== {4'h0, 8'h07, 4'h1, 8'h03})
            $display("FAIL alu_operand_writes: got %0d writes %h/%h %h/%h want 0/07 1/03",
                     wr_a.size() - wb, wr_a[wb], wr_d[wb], wr_a[wb+1], wr_d[wb+1]);
        else pass++;
        chk++;
        if (alu_en_cnt != eb + 1 || alu_func_seen !== 4'h0)
            $display("FAIL alu_en: got %0d pulses func %h want 1 func 0", alu_en_cnt - eb, alu_func_seen);
        else pass++;
        chk++;
        if (fifo_q.size() != fb + 2 || {fifo_q[fb], fifo_q[fb+1]} !== 16'h0A00)
            $display("FAIL alu_add_resp: got %0d bytes %h %h want 0a 00", fifo_q.size() - fb, fifo_q[fb], fifo_q[fb+1]);
        else pass++;
        chk++;
        if (alu_clk_cnt - cb != 2 || ALU_CLK_EN !== 1'b0)
            $display("FAIL alu_clk_en: got %0d cycles now %b want 2 cycles now 0", alu_clk_cnt - cb, ALU_CLK_EN);
        else pass++;
    endtask

    task automatic test_alu_dd();
        int fb;
        fb = fifo_q.size();
        send_byte(8'hDD); send_byte(8'h02);
        idle(10);
        chk++;
        if (fifo_q.size() != fb + 2 || {fifo_q[fb], fifo_q[fb+1]} !== 16'h1500)
            $display("FAIL alu_dd_mul: got %0d bytes %h %h want 15 00", fifo_q.size() - fb, fifo_q[fb], fifo_q[fb+1]);
        else pass++;
        chk++;
        if (alu_func_seen !== 4'h2) $display("FAIL alu_dd_func: got %h want 2", alu_func_seen);
        else pass++;
        fb = fifo_q.size();
        send_byte(8'hCC); send_byte(8'hF0); send_byte(8'h10); send_byte(8'h02);
        idle(10);
        chk++;
        if (fifo_q.size() != fb + 2 || {fifo_q[fb], fifo_q[fb+1]} !== 16'h000F)
            $display("FAIL alu_hi_byte: got %0d bytes %h %h want 00 0f", fifo_q.size() - fb, fifo_q[fb], fifo_q[fb+1]);
        else pass++;
    endtask

    task automatic test_burst_wrap();
        int fb, rb;
        send_byte(8'hAA); send_byte(8'h0E); send_byte(8'h11); idle(3);
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h22); idle(3);
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h33); idle(3);
        fb = fifo_q.size(); rb = rd_cnt;
        send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h03);
        idle(16);
        chk++;
        if (fifo_q.size() != fb + 3 || {fifo_q[fb], fifo_q[fb+1], fifo_q[fb+2]} !== 24'h112233)
            $display("FAIL burst_data: got %0d bytes %h %h %h want 11 22 33",
                     fifo_q.size() - fb, fifo_q[fb], fifo_q[fb+1], fifo_q[fb+2]);
        else pass++;
        chk++;
        if (rd_cnt - rb != 3) $display("FAIL burst_reads: got %0d want 3", rd_cnt - rb);
        else pass++;
    endtask

    task automatic test_backpressure();
        int fb, eb, bad;
        fb = fifo_q.size(); eb = err_cnt; bad = 0;
        FIFO_FULL = 1'b1;
        send_byte(8'hBB); send_byte(8'h05);
        idle(3);
        send_byte(8'h55);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (FIFO_WR !== 1'b0 || TX_DATA_OUT !== 8'h3C) bad++;
            @(posedge CLK); #1;
        end
        chk++;
        if (bad != 0 || fifo_q.size() != fb)
            $display("FAIL stall_hold: got %0d bad cycles %0d writes want 0 0", bad, fifo_q.size() - fb);
        else pass++;
        FIFO_FULL = 1'b0;
        idle(4);
        chk++;
        if (fifo_q.size() != fb + 1 || fifo_q[fb] !== 8'h3C)
            $display("FAIL stall_release: got %0d writes first %h want 1 write 3c", fifo_q.size() - fb, fifo_q[fb]);
        else pass++;
        chk++;
        if (err_cnt != eb || viol != 0)
            $display("FAIL stall_drop: got %0d errors %0d full writes want 0 0", err_cnt - eb, viol);
        else pass++;
    endtask

    task automatic test_errors();
        int fb, eb, rb;
        fb = fifo_q.size(); eb = err_cnt;
        send_byte(8'h55); send_byte(8'hBB); send_byte(8'h05);
        idle(6);
        chk++;
        if (err_cnt != eb + 1) $display("FAIL bad_opcode_err: got %0d pulses want 1", err_cnt - eb);
        else pass++;
        chk++;
        if (fifo_q.size() != fb + 1 || fifo_q[fb] !== 8'h3C)
            $display("FAIL bad_opcode_idle: got %0d bytes first %h want 1 byte 3c", fifo_q.size() - fb, fifo_q[fb]);
        else pass++;
        fb = fifo_q.size(); eb = err_cnt; rb = rd_cnt;
        send_byte(8'hEE); send_byte(8'h00); send_byte(8'h00);
        idle(5);
        chk++;
        if (err_cnt != eb + 1 || rd_cnt != rb || fifo_q.size() != fb)
            $display("FAIL zero_count: got %0d err %0d reads %0d bytes want 1 0 0",
                     err_cnt - eb, rd_cnt - rb, fifo_q.size() - fb);
        else pass++;
    endtask

`ifdef SYS_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int wb, eb, fb, rsc;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h5A); idle(3);
        wb = wr_a.size(); eb = err_cnt; fb = fifo_q.size();
        send_byte(8'hAA); send_byte(8'h02);
        rsc = strobe_cyc;
        idle(30);
        chk++;
        if (err_cnt != eb + 1 || last_err_cyc - rsc != 16)
            $display("FAIL timeout_err: got %0d pulses at +%0d want 1 at +16", err_cnt - eb, last_err_cyc - rsc);
        else pass++;
        chk++;
        if (wr_a.size() != wb) $display("FAIL timeout_nowrite: got %0d writes want 0", wr_a.size() - wb);
        else pass++;
        send_byte(8'hBB); send_byte(8'h02);
        idle(6);
        chk++;
        if (fifo_q.size() != fb + 1 || fifo_q[fb] !== 8'h5A)
            $display("FAIL timeout_recover: got %0d bytes first %h want 1 byte 5a", fifo_q.size() - fb, fifo_q[fb]);
        else pass++;
    endtask
`else
    task automatic test_no_timeout();
        int wb, eb;
        wb = wr_a.size(); eb = err_cnt;
        send_byte(8'hAA); send_byte(8'h02);
        idle(40);
        chk++;
        if (err_cnt != eb || wr_a.size() != wb)
            $display("FAIL partial_wait: got %0d err %0d writes want 0 0", err_cnt - eb, wr_a.size() - wb);
        else pass++;
        send_byte(8'h77);
        idle(3);
        chk++;
        if (wr_a.size() != wb + 1 || {wr_a[wb], wr_d[wb]} !== {4'h2, 8'h77})
            $display("FAIL partial_resume: got %0d writes %h/%h want 1 write 2/77", wr_a.size() - wb, wr_a[wb], wr_d[wb]);
        else pass++;
    endtask
`endif

    task automatic test_reset_mid_frame();
        int fb;
        fb = fifo_q.size();
        FIFO_FULL = 1'b1;
        send_byte(8'hBB); send_byte(8'h05);
        idle(3);
        chk++;
        if (TX_DATA_OUT !== 8'h3C) $display("FAIL pre_reset_tx: got %h want 3c", TX_DATA_OUT);
        else pass++;
        RST = 1'b0;
        #1;
        chk++;
        if ({TX_DATA_OUT, FIFO_WR, CMD_ERROR, RegFile_ADDRESS, RegFile_RdEn, ALU_CLK_EN} !== '0)
            $display("FAIL mid_reset_outputs: got %h want 0",
                     {TX_DATA_OUT, FIFO_WR, CMD_ERROR, RegFile_ADDRESS, RegFile_RdEn, ALU_CLK_EN});
        else pass++;
        FIFO_FULL = 1'b0;
        idle(2);
        RST = 1'b1;
        idle(5);
        chk++;
        if (fifo_q.size() != fb) $display("FAIL no_resume: got %0d writes want 0", fifo_q.size() - fb);
        else pass++;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h99);
        idle(3);
        send_byte(8'hBB); send_byte(8'h03);
        idle(6);
        chk++;
        if (fifo_q.size() != fb + 1 || fifo_q[fb] !== 8'h99)
            $display("FAIL post_reset_frame: got %0d bytes first %h want 1 byte 99", fifo_q.size() - fb, fifo_q[fb]);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alu_ops();
        test_alu_dd();
        test_burst_wrap();
        test_backpressure();
        test_errors();
`ifdef SYS_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
